// File: rtl/freq_counter_pkg.sv
// Shared types and constants for the frequency counter.
// The FSM has two states: idle between measurements, and measure during a gate window.
package freq_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } fc_state_t;

    localparam int unsigned DEFAULT_CLK_HZ = 32'd50_000_000;

endpackage

// File: rtl/freq_counter_sync.sv
// Synchronises an asynchronous input into the clk_in domain and emits a
// one-cycle pulse on each synchronised rising edge (buttons, external pulses).
module sync_edge_detect #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic sig_in,
    output logic rise_pulse
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_q_r;

    // Synchroniser shift chain plus one delayed copy of its output for edge detection
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            sync_r   <= '0;
            sync_q_r <= 1'b0;
        end else begin
            sync_r   <= {sync_r[SYNC_STAGES-2:0], sig_in};
            sync_q_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign rise_pulse = sync_r[SYNC_STAGES-1] & ~sync_q_r;

endmodule

// File: rtl/freq_counter.sv
// Counts synchronised rising edges of sig_in over back-to-back gate windows of
// GATE_CYCLES clocks and publishes each window's total with valid/ack handshake.
module freq_counter
    import freq_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = DEFAULT_CLK_HZ,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             enable,
    input  logic             result_ack,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             result_valid,
    output logic             overrun
);

    localparam int unsigned         GATE_W    = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0]   GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]    ACC_MAX   = {CNT_W{1'b1}};

    fc_state_t          state_r;
    logic [GATE_W-1:0]  gate_r;
    logic [CNT_W-1:0]   acc_r;
    logic               win_ovf_r;
    logic [CNT_W-1:0]   count_r;
    logic               overflow_r;
    logic               result_valid_r;
    logic               overrun_r;

    logic               rise_s;
    logic               sat_now_s;
    logic [CNT_W-1:0]   acc_next_s;
    logic               terminal_s;
    logic               close_s;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .sig_in     (sig_in),
        .rise_pulse (rise_s)
    );

    // Saturating next accumulator value and window-close detection.
    // Overflow means an edge had to be dropped because the accumulator was full.
    always_comb begin
        sat_now_s  = rise_s & (acc_r == ACC_MAX);
        acc_next_s = acc_r;
        if (sat_now_s) begin
            acc_next_s = ACC_MAX;
        end else begin
            acc_next_s = acc_r + {{(CNT_W-1){1'b0}}, rise_s};
        end
        terminal_s = (gate_r == GATE_LAST);
        close_s    = (state_r == MEASURE) & enable & terminal_s;
    end

    // Gate FSM: gate counter and edge accumulator; disable discards the partial window
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            gate_r    <= '0;
            acc_r     <= '0;
            win_ovf_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    gate_r    <= '0;
                    acc_r     <= '0;
                    win_ovf_r <= 1'b0;
                    if (enable) begin
                        state_r <= MEASURE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                MEASURE: begin
                    if (!enable) begin
                        state_r   <= IDLE;
                        gate_r    <= '0;
                        acc_r     <= '0;
                        win_ovf_r <= 1'b0;
                    end else if (terminal_s) begin
                        state_r   <= MEASURE;
                        gate_r    <= '0;
                        acc_r     <= '0;
                        win_ovf_r <= 1'b0;
                    end else begin
                        state_r   <= MEASURE;
                        gate_r    <= gate_r + {{(GATE_W-1){1'b0}}, 1'b1};
                        acc_r     <= acc_next_s;
                        win_ovf_r <= win_ovf_r | sat_now_s;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    gate_r    <= '0;
                    acc_r     <= '0;
                    win_ovf_r <= 1'b0;
                end
            endcase
        end
    end

    // Result registers: a closing window always wins over a simultaneous ack
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            count_r        <= '0;
            overflow_r     <= 1'b0;
            result_valid_r <= 1'b0;
            overrun_r      <= 1'b0;
        end else if (close_s) begin
            count_r        <= acc_next_s;
            overflow_r     <= win_ovf_r | sat_now_s;
            result_valid_r <= 1'b1;
            if (result_ack) begin
                overrun_r <= 1'b0;
            end else if (result_valid_r) begin
                overrun_r <= 1'b1;
            end else begin
                overrun_r <= overrun_r;
            end
        end else if (result_ack) begin
            count_r        <= count_r;
            overflow_r     <= overflow_r;
            result_valid_r <= 1'b0;
            overrun_r      <= 1'b0;
        end else begin
            count_r        <= count_r;
            overflow_r     <= overflow_r;
            result_valid_r <= result_valid_r;
            overrun_r      <= overrun_r;
        end
    end

    assign count        = count_r;
    assign overflow     = overflow_r;
    assign result_valid = result_valid_r;
    assign overrun      = overrun_r;

endmodule

// File: tb/tb_freq_counter.sv
// Directed bench for freq_counter: an 8-bit and a 4-bit instance share all
// inputs with a 100-cycle gate; inputs are driven and outputs sampled at negedge.
module tb_freq_counter;

    logic       clk_in = 1'b0;
    logic       rst_n;
    logic       sig_in;
    logic       enable;
    logic       result_ack;
    logic [7:0] count;
    logic       overflow;
    logic       result_valid;
    logic       overrun;
    logic [3:0] count4;
    logic       overflow4;
    logic       result_valid4;
    logic       overrun4;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   phase = 0;
    int   wave_p = 0;
    logic wave_level = 1'b0;

    freq_counter #(.GATE_CYCLES(100), .CNT_W(8), .SYNC_STAGES(2)) dut (
        .clk_in(clk_in), .rst_n(rst_n), .sig_in(sig_in), .enable(enable),
        .result_ack(result_ack), .count(count), .overflow(overflow),
        .result_valid(result_valid), .overrun(overrun)
    );

    freq_counter #(.GATE_CYCLES(100), .CNT_W(4), .SYNC_STAGES(2)) dut4 (
        .clk_in(clk_in), .rst_n(rst_n), .sig_in(sig_in), .enable(enable),
        .result_ack(result_ack), .count(count4), .overflow(overflow4),
        .result_valid(result_valid4), .overrun(overrun4)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(negedge clk_in);
        cyc = cyc + 1;
        if (wave_p == 0) sig_in = wave_level;
        else             sig_in = ((phase % wave_p) < (wave_p / 2));
        phase = phase + 1;
    endtask

    task automatic set_wave(input int p, input logic lvl);
        wave_p     = p;
        wave_level = lvl;
        phase      = 0;
    endtask

    task automatic ack_pulse();
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
    endtask

    task automatic wait_result(output int at);
        bit got;
        got = 1'b0;
        at  = cyc;
        for (int i = 0; i < 150 && !got; i++) begin
            tick();
            if (result_valid === 1'b1) begin
                got = 1'b1;
                at  = cyc;
            end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL wait_result: result_valid stayed 0 for 150 cycles, expected 1");
        end
    endtask

    task automatic test_reset();
        int seen;
        rst_n = 1'b0; enable = 1'b0; result_ack = 1'b0;
        set_wave(2, 1'b0);
        repeat (3) tick();
        checks++; if (count !== 8'd0) begin failures++; $display("FAIL reset_count: got %0h expected 0", count); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", result_valid); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        checks++; if ({count4, overflow4, result_valid4, overrun4} !== 7'd0) begin
            failures++; $display("FAIL reset_dut4: got %0h expected 0", {count4, overflow4, result_valid4, overrun4});
        end
        rst_n = 1'b1;
        seen = 0;
        repeat (120) begin
            tick();
            if (result_valid !== 1'b0 || result_valid4 !== 1'b0) seen++;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL idle_no_result: got %0d valid cycles expected 0", seen); end
    endtask

    task automatic test_square_wave();
        int at1;
        int at2;
        set_wave(10, 1'b0);
        repeat (20) tick();
        enable = 1'b1;
        wait_result(at1);
        checks++; if (count !== 8'd10) begin failures++; $display("FAIL sq_count1: got %0d expected 10", count); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL sq_overflow1: got %b expected 0", overflow); end
        checks++; if (count4 !== 4'd10) begin failures++; $display("FAIL sq_count4: got %0d expected 10", count4); end
        ack_pulse();
        checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL sq_ack_clears: got %b expected 0", result_valid); end
        wait_result(at2);
        checks++; if (at2 - at1 != 100) begin failures++; $display("FAIL sq_interval: got %0d expected 100", at2 - at1); end
        checks++; if (count !== 8'd10) begin failures++; $display("FAIL sq_count2: got %0d expected 10", count); end
        ack_pulse();
    endtask

    task automatic test_constant();
        int at;
        set_wave(0, 1'b0);
        wait_result(at); ack_pulse();
        wait_result(at);
        checks++; if (count !== 8'd0) begin failures++; $display("FAIL const0_count: got %0d expected 0", count); end
        ack_pulse();
        set_wave(0, 1'b1);
        wait_result(at); ack_pulse();
        wait_result(at);
        checks++; if (count !== 8'd0) begin failures++; $display("FAIL const1_count: got %0d expected 0", count); end
        checks++; if (count4 !== 4'd0) begin failures++; $display("FAIL const1_count4: got %0d expected 0", count4); end
        ack_pulse();
    endtask

    task automatic test_saturation();
        int at;
        set_wave(4, 1'b0);
        wait_result(at); ack_pulse();
        wait_result(at);
        checks++; if (count4 !== 4'd15) begin failures++; $display("FAIL sat_count4: got %0d expected 15", count4); end
        checks++; if (overflow4 !== 1'b1) begin failures++; $display("FAIL sat_overflow4: got %b expected 1", overflow4); end
        checks++; if (count !== 8'd25) begin failures++; $display("FAIL sat_count8: got %0d expected 25", count); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL sat_overflow8: got %b expected 0", overflow); end
        ack_pulse();
        set_wave(20, 1'b0);
        wait_result(at); ack_pulse();
        wait_result(at);
        checks++; if (count4 !== 4'd5) begin failures++; $display("FAIL unsat_count4: got %0d expected 5", count4); end
        checks++; if (overflow4 !== 1'b0) begin failures++; $display("FAIL unsat_overflow4: got %b expected 0", overflow4); end
        ack_pulse();
    endtask

    task automatic test_overrun();
        int at;
        set_wave(10, 1'b0);
        wait_result(at);
        repeat (100) tick();
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_set: got %b expected 1", overrun); end
        checks++; if (result_valid !== 1'b1) begin failures++; $display("FAIL overrun_valid: got %b expected 1", result_valid); end
        checks++; if (count !== 8'd10) begin failures++; $display("FAIL overrun_count: got %0d expected 10", count); end
        repeat (99) tick();
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_sticky: got %b expected 1", overrun); end
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        checks++; if (result_valid !== 1'b1) begin failures++; $display("FAIL ack_close_valid: got %b expected 1", result_valid); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ack_close_overrun: got %b expected 0", overrun); end
        ack_pulse();
        checks++; if (result_valid !== 1'b0) begin failures++; $display("FAIL ack_after_close: got %b expected 0", result_valid); end
    endtask

    task automatic test_enable_and_reset();
        int at;
        int seen;
        wait_result(at);
        ack_pulse();
        seen = 0;
        while (cyc < at + 50) begin tick(); if (result_valid !== 1'b0) seen++; end
        enable = 1'b0;
        repeat (5) begin tick(); if (result_valid !== 1'b0) seen++; end
        enable = 1'b1;
        while (cyc < at + 155) begin tick(); if (result_valid !== 1'b0) seen++; end
        checks++; if (seen != 0) begin failures++; $display("FAIL disable_no_result: got %0d valid cycles expected 0", seen); end
        tick();
        checks++; if (result_valid !== 1'b1) begin failures++; $display("FAIL reenable_latency: got %b expected 1", result_valid); end
        checks++; if (count !== 8'd10) begin failures++; $display("FAIL reenable_count: got %0d expected 10", count); end
        at = cyc;
        ack_pulse();
        while (cyc < at + 70) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if ({count, overflow, result_valid, overrun} !== 11'd0) begin
            failures++; $display("FAIL midreset_outputs: got %0h expected 0", {count, overflow, result_valid, overrun});
        end
        checks++; if (count4 !== 4'd0) begin failures++; $display("FAIL midreset_count4: got %0d expected 0", count4); end
        seen = 0;
        while (cyc < at + 171) begin tick(); if (result_valid !== 1'b0) seen++; end
        checks++; if (seen != 0) begin failures++; $display("FAIL midreset_no_flags: got %0d valid cycles expected 0", seen); end
        tick();
        checks++; if (result_valid !== 1'b1) begin failures++; $display("FAIL midreset_restart: got %b expected 1", result_valid); end
        ack_pulse();
    endtask

    initial begin
        sig_in = 1'b0;
        test_reset();
        test_square_wave();
        test_constant();
        test_saturation();
        test_overrun();
        test_enable_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
